sound_audio_decimator: RTL and testbench

- Downstream of the GLU/DOC stage.
- Consumes the GLU's volume-scaled, noise-gated signed 16-bit stereo samples, which update at clk_logic rate.
- Box-car averages them over power-of-two windows.
- On each output-rate tick (48 kHz), captures the latest average into a small FIFO, with an optional DC blocker in front of it. The audio serializer (HDMI/I2S) drains the FIFO over a valid/ready handshake.

---
 rtl/sound_pkg.sv | 21 ++
 rtl/sound_sample_fifo.sv | 59 +++++
 rtl/sound_audio_decimator.sv | 142 ++++++++++++++
 tb/tb_sound_audio_decimator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and helpers for the audio decimator: stereo sample struct and 16-bit saturation.
package sound_pkg;

    localparam int AUDIO_W = 16;

    typedef struct packed {
        logic signed [AUDIO_W-1:0] l;
        logic signed [AUDIO_W-1:0] r;
    } audio_sample_t;

    function automatic logic signed [AUDIO_W-1:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7fff;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[AUDIO_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sound_sample_fifo.sv
// First-word-fall-through FIFO of stereo samples; head is a register read through the read pointer.
module sound_sample_fifo
    import sound_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_logic,
    input  logic                     system_reset_n,
    input  logic                     push,
    input  audio_sample_t            push_data,
    input  logic                     pop,
    output audio_sample_t            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    audio_sample_t  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sound_audio_decimator.sv
// Box-car decimator: averages GLU stereo samples over 2^LOG2_AVG inputs and queues one pair per rate tick.
// Optional DC blocker before the FIFO is enabled by defining SOUND_DC_BLOCK_EN.
module sound_audio_decimator
    import sound_pkg::*;
#(
    parameter int LOG2_AVG   = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int DC_SHIFT   = 10
) (
    input  logic                            clk_logic,
    input  logic                            system_reset_n,
    input  logic                            sample_en_i,
    input  logic signed [15:0]              audio_l_i,
    input  logic signed [15:0]              audio_r_i,
    input  logic                            rate_tick_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic signed [15:0]              out_l_o,
    output logic signed [15:0]              out_r_o,
    output logic [$clog2(FIFO_DEPTH):0]     fill_o,
    output logic                            overflow_o,
    input  logic                            clear_overflow_i
);

    localparam int AW = AUDIO_W + LOG2_AVG;

    if (LOG2_AVG < 1 || LOG2_AVG > 6 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DC_SHIFT < 1) begin : g_bad_cfg
        $error("sound_audio_decimator: unsupported parameter set");
    end

    logic signed [AW-1:0] acc_l;
    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] sum_l;
    logic signed [AW-1:0] sum_r;
    logic [LOG2_AVG-1:0]  win_cnt;
    audio_sample_t        hold;

    assign sum_l = acc_l + {{LOG2_AVG{audio_l_i[AUDIO_W-1]}}, audio_l_i};
    assign sum_r = acc_r + {{LOG2_AVG{audio_r_i[AUDIO_W-1]}}, audio_r_i};

    // Dropping the low LOG2_AVG bits is the floor division; the mean always fits 16 bits.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            acc_l   <= '0;
            acc_r   <= '0;
            win_cnt <= '0;
            hold    <= '0;
        end else if (sample_en_i) begin
            win_cnt <= win_cnt + LOG2_AVG'(1);
            if (&win_cnt) begin
                hold.l <= sum_l[AW-1:LOG2_AVG];
                hold.r <= sum_r[AW-1:LOG2_AVG];
                acc_l  <= '0;
                acc_r  <= '0;
            end else begin
                acc_l  <= sum_l;
                acc_r  <= sum_r;
            end
        end
    end

    logic          push;
    audio_sample_t push_data;

`ifdef SOUND_DC_BLOCK_EN
    audio_sample_t x_prev;
    audio_sample_t y_prev;
    audio_sample_t dc_out;
    audio_sample_t dc_next;
    logic          dc_push;

    function automatic logic signed [15:0] dc_step(input logic signed [15:0] x,
                                                   input logic signed [15:0] xp,
                                                   input logic signed [15:0] yp);
        logic signed [17:0] y;
        y = 18'(x) - 18'(xp) + 18'(yp) - 18'(yp >>> DC_SHIFT);
        return sat16(y);
    endfunction

    assign dc_next.l = dc_step(hold.l, x_prev.l, y_prev.l);
    assign dc_next.r = dc_step(hold.r, x_prev.r, y_prev.r);

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            x_prev  <= '0;
            y_prev  <= '0;
            dc_out  <= '0;
            dc_push <= 1'b0;
        end else begin
            dc_push <= rate_tick_i;
            if (rate_tick_i) begin
                x_prev <= hold;
                y_prev <= dc_next;
                dc_out <= dc_next;
            end
        end
    end

    assign push      = dc_push;
    assign push_data = dc_out;
`else
    assign push      = rate_tick_i;
    assign push_data = hold;
`endif

    audio_sample_t head;
    logic          full;
    logic          empty;
    logic          pop;

    assign out_valid_o = !empty;
    assign pop         = out_valid_o && out_ready_i;
    assign out_l_o     = head.l;
    assign out_r_o     = head.r;

    sound_sample_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .push           (push),
        .push_data      (push_data),
        .pop            (pop),
        .head           (head),
        .full           (full),
        .empty          (empty),
        .count          (fill_o)
    );

    // A fresh overflow takes priority over a coincident clear.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            overflow_o <= 1'b0;
        end else if (push && full && !pop) begin
            overflow_o <= 1'b1;
        end else if (clear_overflow_i) begin
            overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sound_audio_decimator.sv
// Bench for sound_audio_decimator (default build): directed vector table, corner sequences, random vs model.
module tb_sound_audio_decimator;

    localparam int LOG2_AVG   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int WIN        = 1 << LOG2_AVG;

    logic               clk_logic = 1'b0;
    logic               system_reset_n = 1'b0;
    logic               sample_en_i = 1'b0;
    logic signed [15:0] audio_l_i = '0;
    logic signed [15:0] audio_r_i = '0;
    logic               rate_tick_i = 1'b0;
    logic               out_valid_o;
    logic               out_ready_i = 1'b0;
    logic signed [15:0] out_l_o;
    logic signed [15:0] out_r_o;
    logic [$clog2(FIFO_DEPTH):0] fill_o;
    logic               overflow_o;
    logic               clear_overflow_i = 1'b0;

    int n_compared = 0;
    int n_mismatched = 0;

    sound_audio_decimator #(
        .LOG2_AVG   (LOG2_AVG),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DC_SHIFT   (10)
    ) dut (
        .clk_logic        (clk_logic),
        .system_reset_n   (system_reset_n),
        .sample_en_i      (sample_en_i),
        .audio_l_i        (audio_l_i),
        .audio_r_i        (audio_r_i),
        .rate_tick_i      (rate_tick_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_l_o          (out_l_o),
        .out_r_o          (out_r_o),
        .fill_o           (fill_o),
        .overflow_o       (overflow_o),
        .clear_overflow_i (clear_overflow_i)
    );

    always #5 clk_logic = ~clk_logic;

    task automatic check(input string name, input int act, input int exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic cycle(input bit se, input int l, input int r, input bit tk, input bit rd, input bit clr);
        sample_en_i      = se;
        audio_l_i        = 16'(l);
        audio_r_i        = 16'(r);
        rate_tick_i      = tk;
        out_ready_i      = rd;
        clear_overflow_i = clr;
        @(posedge clk_logic);
        #1;
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 0);
        system_reset_n = 1'b0;
        repeat (2) @(posedge clk_logic);
        @(negedge clk_logic);
        system_reset_n = 1'b1;
    endtask

    task automatic feed_window(input int v);
        for (int i = 0; i < WIN; i++) cycle(1, v, -v, 0, 0, 0);
    endtask

    task automatic check_head(input string name, input int l, input int r, input int fill);
        check({name, "_valid"}, int'(out_valid_o), 1);
        check({name, "_l"}, int'(out_l_o), l);
        check({name, "_r"}, int'(out_r_o), r);
        check({name, "_fill"}, int'(fill_o), fill);
    endtask

    // Behavioural reference: windowed mean with floor rounding and a bounded queue.
    int m_q_l[$];
    int m_q_r[$];
    int m_hold_l, m_hold_r, m_sum_l, m_sum_r, m_n;
    bit m_ovf;

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_q_l.delete();
        m_q_r.delete();
        m_hold_l = 0; m_hold_r = 0; m_sum_l = 0; m_sum_r = 0; m_n = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit se, input int l, input int r, input bit tk, input bit rd, input bit clr);
        bit was_full;
        bit popped;
        bit set_ovf;
        was_full = (m_q_l.size() == FIFO_DEPTH);
        popped   = rd && (m_q_l.size() > 0);
        set_ovf  = 0;
        if (popped) begin
            void'(m_q_l.pop_front());
            void'(m_q_r.pop_front());
        end
        if (tk) begin
            if (!was_full || popped) begin
                m_q_l.push_back(m_hold_l);
                m_q_r.push_back(m_hold_r);
            end else begin
                set_ovf = 1;
            end
        end
        if (set_ovf) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (se) begin
            m_sum_l += l;
            m_sum_r += r;
            m_n++;
            if (m_n == WIN) begin
                m_hold_l = floor_div(m_sum_l, WIN);
                m_hold_r = floor_div(m_sum_r, WIN);
                m_sum_l = 0; m_sum_r = 0; m_n = 0;
            end
        end
    endtask

    typedef struct {
        bit se; int l; int r; bit tk; bit rd; bit clr;
        bit ev; int el; int er; int ef; bit eo;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // inputs (se, l, r, tick, ready, clr) -> expected (valid, l, r, fill, overflow)
        tbl.push_back('{0,    0,     0, 1, 0, 0,  1,   0,     0, 1, 0}); // tick before any window
        tbl.push_back('{0,    0,     0, 0, 1, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{1,  100, 32767, 0, 0, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{1,  200, 32767, 0, 0, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{1,  300, 32767, 0, 0, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{1,  400, 32767, 0, 0, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{0,    0,     0, 1, 0, 0,  1, 250, 32767, 1, 0});
        tbl.push_back('{0,    0,     0, 0, 1, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{1,   -1, 32767, 0, 0, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{1,   -2, 32767, 0, 0, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{1,   -3, 32767, 0, 0, 0,  0,   0,     0, 0, 0});
        tbl.push_back('{1,   -4, 32767, 1, 0, 0,  1, 250, 32767, 1, 0}); // window end with tick: old hold
        tbl.push_back('{0,    0,     0, 1, 0, 0,  1, 250, 32767, 2, 0}); // floor(-2.5) queued behind
        tbl.push_back('{0,    0,     0, 0, 1, 0,  1,  -3, 32767, 1, 0});
        tbl.push_back('{0,    0,     0, 0, 1, 0,  0,   0,     0, 0, 0});

        do_reset();
        #1;
        check("reset_valid", int'(out_valid_o), 0);
        check("reset_l", int'(out_l_o), 0);
        check("reset_r", int'(out_r_o), 0);
        check("reset_fill", int'(fill_o), 0);
        check("reset_ovf", int'(overflow_o), 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].se, tbl[i].l, tbl[i].r, tbl[i].tk, tbl[i].rd, tbl[i].clr);
            check($sformatf("vec%0d_valid", i), int'(out_valid_o), int'(tbl[i].ev));
            check($sformatf("vec%0d_fill", i), int'(fill_o), tbl[i].ef);
            check($sformatf("vec%0d_ovf", i), int'(overflow_o), int'(tbl[i].eo));
            if (tbl[i].ev) begin
                check($sformatf("vec%0d_l", i), int'(out_l_o), tbl[i].el);
                check($sformatf("vec%0d_r", i), int'(out_r_o), tbl[i].er);
            end
        end

        // Overflow: five ticks into a 4-deep FIFO, the fifth value is lost.
        for (int k = 1; k <= 5; k++) begin
            feed_window(10 * k);
            cycle(0, 0, 0, 1, 0, 0);
        end
        check_head("ovf_full", 10, -10, 4);
        check("ovf_set", int'(overflow_o), 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("ovf_clear", int'(overflow_o), 0);

        // Full FIFO with tick and pop together: both succeed, no overflow.
        feed_window(60);
        cycle(0, 0, 0, 1, 1, 0);
        check_head("pushpop_full", 20, -20, 4);
        check("pushpop_ovf", int'(overflow_o), 0);

        // Clear coinciding with a new overflow: the set wins.
        feed_window(70);
        cycle(0, 0, 0, 1, 0, 1);
        check("ovf_set_wins", int'(overflow_o), 1);
        check("ovf_set_wins_fill", int'(fill_o), 4);
        cycle(0, 0, 0, 0, 0, 1);
        check("ovf_clear2", int'(overflow_o), 0);

        begin
            int exp_q[$];
            exp_q = '{20, 30, 40, 60};
            foreach (exp_q[i]) begin
                check_head($sformatf("drain%0d", i), exp_q[i], -exp_q[i], 4 - i);
                cycle(0, 0, 0, 0, 1, 0);
            end
        end
        check("drain_empty_valid", int'(out_valid_o), 0);
        check("drain_empty_fill", int'(fill_o), 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("pop_empty_fill", int'(fill_o), 0);

        // Reset mid-window with three queued entries.
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0, 0);
        check("pre_reset_fill", int'(fill_o), 3);
        cycle(1, 1000, 1000, 0, 0, 0);
        cycle(1, 1000, 1000, 0, 0, 0);
        system_reset_n = 1'b0;
        #1;
        check("async_reset_valid", int'(out_valid_o), 0);
        check("async_reset_fill", int'(fill_o), 0);
        @(negedge clk_logic);
        system_reset_n = 1'b1;
        cycle(0, 0, 0, 1, 0, 0);
        check_head("post_reset_zero", 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0);
        feed_window(8);
        cycle(0, 0, 0, 1, 0, 0);
        check_head("post_reset_window", 8, -8, 1);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit se, tk, rd, clr;
            logic signed [15:0] rl, rr;
            int l, r;
            se  = ($urandom_range(0, 3) != 0);
            tk  = ($urandom_range(0, 5) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 19) == 0);
            rl  = 16'($urandom);
            rr  = 16'($urandom);
            l = int'(rl);
            r = int'(rr);
            model_step(se, l, r, tk, rd, clr);
            cycle(se, l, r, tk, rd, clr);
            check("rand_valid", int'(out_valid_o), int'(m_q_l.size() > 0));
            check("rand_fill", int'(fill_o), m_q_l.size());
            check("rand_ovf", int'(overflow_o), int'(m_ovf));
            if (m_q_l.size() > 0) begin
                check("rand_l", int'(out_l_o), m_q_l[0]);
                check("rand_r", int'(out_r_o), m_q_r[0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
